mlsu_mctrl_seq: RTL and testbench

Matrix load/store request sequencer for the MLSU. Accepts one matrix memory instruction at a time: base, byte stride, rows, cols, element width and a one-hot layout mode (row-major, col-major, transpose, reshape). Expands it into a stream of per-line memory requests under valid/ready, then signals completion. Sits between the MLSU instruction queue and the memory request/address-generation port.

---
 rtl/mlsu_mctrl_pkg.sv | 68 ++++++
 rtl/mlsu_mctrl_agen.sv | 69 ++++++
 rtl/mlsu_mctrl_seq.sv | 214 +++++++++++++++++++++
 tb/tb_mlsu_mctrl_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlsu_mctrl_pkg.sv
// mlsu_mctrl_pkg
//   Shared types and helpers for the MLSU matrix load/store request sequencer.
//   Holds the one-hot layout mode type and its bit positions, the FSM state
//   enum, the instruction and request bundles, and mode decode helpers.
//   The packed bundles are sized from the MCTRL_* width constants below; the
//   sequencer's width parameters default to these and must match them.

package mlsu_mctrl_pkg;

    localparam int MCTRL_ADDR_W    = 32;
    localparam int MCTRL_DIM_W     = 8;
    localparam int MCTRL_ID_W      = 4;
    localparam int MCTRL_MAX_BURST = 16;

    localparam int MODE_ROW = 0;
    localparam int MODE_COL = 1;
    localparam int MODE_TXP = 2;
    localparam int MODE_RSH = 3;

    typedef logic [3:0] mode_oh_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        mode_oh_t                  mode;
        logic [MCTRL_ADDR_W-1:0]   base;
        logic [MCTRL_ADDR_W-1:0]   stride;
        logic [MCTRL_DIM_W-1:0]    rows;
        logic [MCTRL_DIM_W-1:0]    cols;
        logic [1:0]                eew;
        logic [MCTRL_ID_W-1:0]     id;
    } instr_t;

    typedef struct packed {
        logic [MCTRL_ADDR_W-1:0]   addr;
        logic [2*MCTRL_DIM_W-1:0]  len;
        logic [2*MCTRL_DIM_W-1:0]  idx;
        logic                      txp;
        logic                      last;
        logic [MCTRL_ID_W-1:0]     id;
    } req_t;

    function automatic logic is_row_major(input mode_oh_t m);
        return m[MODE_ROW];
    endfunction

    function automatic logic is_col_major(input mode_oh_t m);
        return m[MODE_COL];
    endfunction

    function automatic logic is_transpose(input mode_oh_t m);
        return m[MODE_TXP];
    endfunction

    function automatic logic is_reshape(input mode_oh_t m);
        return m[MODE_RSH];
    endfunction

    // Exactly one bit set.
    function automatic logic mode_legal(input mode_oh_t m);
        return (m != '0) && ((m & (m - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/mlsu_mctrl_agen.sv
// mlsu_mctrl_agen
//   Address generator / line counter for the sequencer. On load it captures
//   the base address, address step, line count and line lengths; each
//   advance moves to the next line (address += step, index += 1).
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     load_i                capture a new instruction's line parameters
//     base_i, step_i        first line address and per-line address step
//     lines_i               number of lines (N), must be >0 when used
//     len_full_i/len_last_i length of every line but the last / of the last
//     adv_i                 current line handed off, move to the next
//     addr_o, idx_o         current line address and index
//     len_o, last_o         current line length and final-line flag

module mlsu_mctrl_agen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] step_i,
    input  logic [CNT_W-1:0]  lines_i,
    input  logic [CNT_W-1:0]  len_full_i,
    input  logic [CNT_W-1:0]  len_last_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  idx_o,
    output logic [CNT_W-1:0]  len_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] step_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  lines_m1_q;
    logic [CNT_W-1:0]  len_full_q;
    logic [CNT_W-1:0]  len_last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            lines_m1_q <= '0;
            len_full_q <= '0;
            len_last_q <= '0;
        end else if (load_i) begin
            addr_q     <= base_i;
            step_q     <= step_i;
            idx_q      <= '0;
            // Storing N-1 keeps the last-line test a plain equality.
            lines_m1_q <= lines_i - CNT_W'(1);
            len_full_q <= len_full_i;
            len_last_q <= len_last_i;
        end else if (adv_i) begin
            // Wraps modulo 2^ADDR_W by design.
            addr_q <= addr_q + step_q;
            idx_q  <= idx_q + CNT_W'(1);
        end
    end

    assign addr_o = addr_q;
    assign idx_o  = idx_q;
    assign last_o = (idx_q == lines_m1_q);
    assign len_o  = last_o ? len_last_q : len_full_q;

endmodule

// File: rtl/mlsu_mctrl_seq.sv
// mlsu_mctrl_seq
//   Matrix load/store request sequencer. Accepts one matrix memory
//   instruction at a time and expands it into per-line memory requests
//   under valid/ready, then pulses done.
//
//   state | meaning
//   IDLE  | ready for an instruction
//   ISSUE | presenting requests, one per handshake
//   DONE  | one-cycle completion pulse (done_o)
//
//   Ports:
//     clk_i, rst_i           clock, synchronous active-high reset
//     instr_*                instruction offer/accept and fields
//     req_*                  per-line memory request stream
//     done_o/err/id          completion pulse, illegal-mode flag, tag
//     busy_o                 not idle
//     perf_stall_o           (MCTRL_PERF_CNT_EN only) saturating count of
//                            cycles with req_valid_o & !req_ready_i
//   Build option: define MCTRL_PERF_CNT_EN to add perf_stall_o.

module mlsu_mctrl_seq
    import mlsu_mctrl_pkg::*;
#(
    parameter int ADDR_W    = MCTRL_ADDR_W,
    parameter int DIM_W     = MCTRL_DIM_W,
    parameter int MAX_BURST = MCTRL_MAX_BURST,
    parameter int ID_W      = MCTRL_ID_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [3:0]           instr_mode_i,
    input  logic [ADDR_W-1:0]    instr_base_i,
    input  logic [ADDR_W-1:0]    instr_stride_i,
    input  logic [DIM_W-1:0]     instr_rows_i,
    input  logic [DIM_W-1:0]     instr_cols_i,
    input  logic [1:0]           instr_eew_i,
    input  logic [ID_W-1:0]      instr_id_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [ADDR_W-1:0]    req_addr_o,
    output logic [2*DIM_W-1:0]   req_len_o,
    output logic [2*DIM_W-1:0]   req_idx_o,
    output logic                 req_txp_o,
    output logic                 req_last_o,
    output logic [ID_W-1:0]      req_id_o,
    output logic                 done_o,
    output logic                 done_err_o,
    output logic [ID_W-1:0]      done_id_o,
    output logic                 busy_o
`ifdef MCTRL_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_o
`endif
);

    localparam int CNT_W    = 2 * DIM_W;
    localparam int BURST_LG = $clog2(MAX_BURST);

    if (ADDR_W != MCTRL_ADDR_W || DIM_W != MCTRL_DIM_W || ID_W != MCTRL_ID_W) begin : g_width_check
        $error("mlsu_mctrl_seq: width parameters must match mlsu_mctrl_pkg");
    end

    state_e state_q, state_n;
    logic   err_q;
    logic   txp_q;
    logic [ID_W-1:0] id_q;

    instr_t instr;
    logic   accept;
    logic   legal;
    logic   zero_dim;
    logic   adv;

    logic [CNT_W-1:0]    rows_ext, cols_ext, total;
    logic [BURST_LG-1:0] rsh_tail;
    logic [CNT_W-1:0]    line_cnt, len_full, len_last;
    logic [ADDR_W-1:0]   step;

    logic [ADDR_W-1:0]   agen_addr;
    logic [CNT_W-1:0]    agen_idx, agen_len;
    logic                agen_last;

    req_t req;

    assign instr = {instr_mode_i, instr_base_i, instr_stride_i, instr_rows_i,
                    instr_cols_i, instr_eew_i, instr_id_i};

    assign instr_ready_o = (state_q == IDLE);
    assign accept        = instr_valid_i & instr_ready_o;
    assign legal         = mode_legal(instr.mode);
    assign zero_dim      = (instr.rows == '0) || (instr.cols == '0);
    // Ready outside ISSUE never advances the line counter.
    assign adv           = (state_q == ISSUE) & req_ready_i;

    // Line geometry, computed from the live fields in the accept cycle.
    assign rows_ext = CNT_W'(instr.rows);
    assign cols_ext = CNT_W'(instr.cols);
    assign total    = rows_ext * cols_ext;
    assign rsh_tail = total[BURST_LG-1:0];

    always_comb begin
        line_cnt = rows_ext;
        len_full = cols_ext;
        len_last = cols_ext;
        step     = instr.stride;
        if (is_col_major(instr.mode)) begin
            line_cnt = cols_ext;
            len_full = rows_ext;
            len_last = rows_ext;
        end else if (is_reshape(instr.mode)) begin
            // ceil(T / MAX_BURST); a partial tail line carries T mod MAX_BURST.
            line_cnt = (total >> BURST_LG) + CNT_W'(rsh_tail != '0);
            len_full = CNT_W'(MAX_BURST);
            len_last = (rsh_tail == '0) ? CNT_W'(MAX_BURST) : CNT_W'(rsh_tail);
            step     = ADDR_W'(MAX_BURST) << instr.eew;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            txp_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                err_q <= ~legal;
                txp_q <= is_transpose(instr.mode);
                id_q  <= instr.id;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legal || zero_dim) state_n = DONE;
                    else                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready_i && agen_last) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    mlsu_mctrl_agen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_agen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .base_i     (instr.base),
        .step_i     (step),
        .lines_i    (line_cnt),
        .len_full_i (len_full),
        .len_last_i (len_last),
        .adv_i      (adv),
        .addr_o     (agen_addr),
        .idx_o      (agen_idx),
        .len_o      (agen_len),
        .last_o     (agen_last)
    );

    // Request fields are forced to zero outside ISSUE so stale line data
    // from a previous instruction never shows on the port.
    always_comb begin
        req = '0;
        if (state_q == ISSUE) begin
            req.addr = agen_addr;
            req.len  = agen_len;
            req.idx  = agen_idx;
            req.txp  = txp_q;
            req.last = agen_last;
            req.id   = id_q;
        end
    end

    assign req_valid_o = (state_q == ISSUE);
    assign req_addr_o  = req.addr;
    assign req_len_o   = req.len;
    assign req_idx_o   = req.idx;
    assign req_txp_o   = req.txp;
    assign req_last_o  = req.last;
    assign req_id_o    = req.id;

    assign done_o     = (state_q == DONE);
    assign done_err_o = done_o & err_q;
    assign done_id_o  = done_o ? id_q : '0;
    assign busy_o     = (state_q != IDLE);

`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (req_valid_o && !req_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_mlsu_mctrl_seq.sv
module tb_mlsu_mctrl_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [3:0]  instr_mode_i;
    logic [31:0] instr_base_i;
    logic [31:0] instr_stride_i;
    logic [7:0]  instr_rows_i;
    logic [7:0]  instr_cols_i;
    logic [1:0]  instr_eew_i;
    logic [3:0]  instr_id_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic [15:0] req_len_o;
    logic [15:0] req_idx_o;
    logic        req_txp_o;
    logic        req_last_o;
    logic [3:0]  req_id_o;
    logic        done_o;
    logic        done_err_o;
    logic [3:0]  done_id_o;
    logic        busy_o;
`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] perf_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    // Ready source: fixed level, or a level that toggles every cycle.
    logic rdy_fix = 1'b1;
    logic rdy_tog = 1'b0;
    logic tog     = 1'b0;
    assign req_ready_i = tog ? rdy_tog : rdy_fix;

    always @(posedge clk_i) begin
        #1;
        rdy_tog = ~rdy_tog;
    end

    mlsu_mctrl_seq dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .instr_mode_i   (instr_mode_i),
        .instr_base_i   (instr_base_i),
        .instr_stride_i (instr_stride_i),
        .instr_rows_i   (instr_rows_i),
        .instr_cols_i   (instr_cols_i),
        .instr_eew_i    (instr_eew_i),
        .instr_id_i     (instr_id_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_addr_o     (req_addr_o),
        .req_len_o      (req_len_o),
        .req_idx_o      (req_idx_o),
        .req_txp_o      (req_txp_o),
        .req_last_o     (req_last_o),
        .req_id_o       (req_id_o),
        .done_o         (done_o),
        .done_err_o     (done_err_o),
        .done_id_o      (done_id_o),
        .busy_o         (busy_o)
`ifdef MCTRL_PERF_CNT_EN
        ,
        .perf_stall_o   (perf_stall_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        logic [15:0] idx;
        logic        txp;
        logic        last;
        logic [3:0]  id;
    } exp_req_t;

    exp_req_t exp_q[$];
    int       tests     = 0;
    int       fails     = 0;
    int       stall_cnt = 0;
    logic     exp_err;
    logic [3:0] exp_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference expansion of one instruction into expected requests.
    task automatic push_expect(input logic [3:0] mode, input logic [31:0] base,
                               input logic [31:0] stride, input logic [7:0] rows,
                               input logic [7:0] cols, input logic [1:0] eew,
                               input logic [3:0] id);
        int t, n, l;
        logic [31:0] stp;
        exp_req_t e;
        exp_id  = id;
        exp_err = ($countones(mode) != 1);
        if (exp_err || rows == 0 || cols == 0) return;
        t   = int'(rows) * int'(cols);
        stp = stride;
        n   = int'(rows);
        l   = int'(cols);
        if (mode == 4'b0010) begin
            n = int'(cols);
            l = int'(rows);
        end else if (mode == 4'b1000) begin
            n   = (t + 15) / 16;
            l   = 16;
            stp = 32'd16 << eew;
        end
        for (int k = 0; k < n; k++) begin
            e.addr = base + 32'(k) * stp;
            e.len  = (mode == 4'b1000 && k == n - 1) ? 16'(t - 16 * (n - 1)) : 16'(l);
            e.idx  = 16'(k);
            e.txp  = (mode == 4'b0100);
            e.last = (k == n - 1);
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard side: pop and compare on every request handshake; check
    // that a stalled request holds its fields.
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_addr;
    logic [15:0] prev_idx, prev_len;
    logic        prev_last;

    always @(negedge clk_i) begin
        if (req_valid_o) begin
            if (prev_stalled) begin
                chk("stall_addr_stable", req_addr_o, prev_addr);
                chk("stall_idx_stable", req_idx_o, prev_idx);
                chk("stall_len_stable", req_len_o, prev_len);
                chk("stall_last_stable", req_last_o, prev_last);
            end
            if (req_ready_i) begin
                prev_stalled = 1'b0;
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_req observed=idx%0d expected=none", req_idx_o);
                end
                if (exp_q.size() != 0) begin
                    exp_req_t e;
                    e = exp_q.pop_front();
                    chk("req_addr", req_addr_o, e.addr);
                    chk("req_len", req_len_o, e.len);
                    chk("req_idx", req_idx_o, e.idx);
                    chk("req_txp", req_txp_o, e.txp);
                    chk("req_last", req_last_o, e.last);
                    chk("req_id", req_id_o, e.id);
                end
            end else begin
                stall_cnt++;
                prev_stalled = 1'b1;
                prev_addr    = req_addr_o;
                prev_idx     = req_idx_o;
                prev_len     = req_len_o;
                prev_last    = req_last_o;
            end
        end else begin
            prev_stalled = 1'b0;
        end
    end

    task automatic issue(input logic [3:0] mode, input logic [31:0] base,
                         input logic [31:0] stride, input logic [7:0] rows,
                         input logic [7:0] cols, input logic [1:0] eew,
                         input logic [3:0] id);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (instr_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("instr_ready_wait", got, 1);
        push_expect(mode, base, stride, rows, cols, eew, id);
        instr_mode_i   = mode;
        instr_base_i   = base;
        instr_stride_i = stride;
        instr_rows_i   = rows;
        instr_cols_i   = cols;
        instr_eew_i    = eew;
        instr_id_i     = id;
        instr_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        instr_valid_i  = 1'b0;
        instr_mode_i   = 4'($urandom);
        instr_base_i   = $urandom;
        instr_stride_i = $urandom;
        instr_rows_i   = 8'($urandom);
        instr_cols_i   = 8'($urandom);
        instr_eew_i    = 2'($urandom);
        instr_id_i     = 4'($urandom);
    endtask

    // Waits for done after an accept; exp_cyc is the negedge count after
    // the accept edge at which done_o must be seen (0 = do not check).
    task automatic wait_done(input string tag, input int exp_cyc);
        bit seen = 1'b0;
        int n    = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_done_err"}, done_err_o, exp_err);
            chk({tag, "_done_id"}, done_id_o, exp_id);
            chk({tag, "_busy_in_done"}, busy_o, 1);
            if (exp_cyc != 0) chk({tag, "_done_cycle"}, n, exp_cyc);
        end
        chk({tag, "_all_reqs_seen"}, exp_q.size(), 0);
        @(negedge clk_i);
        chk({tag, "_done_one_cycle"}, done_o, 0);
        chk({tag, "_ready_after"}, instr_ready_o, 1);
        chk({tag, "_idle_after"}, busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i          = 1'b1;
        instr_valid_i  = 1'b0;
        instr_mode_i   = '0;
        instr_base_i   = '0;
        instr_stride_i = '0;
        instr_rows_i   = '0;
        instr_cols_i   = '0;
        instr_eew_i    = '0;
        instr_id_i     = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_req_addr", req_addr_o, 0);
        chk("rst_req_last", req_last_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_done_err", done_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_instr_ready", instr_ready_o, 1);
`ifdef MCTRL_PERF_CNT_EN
        chk("rst_perf", perf_stall_o, 0);
`endif
        rst_i = 1'b0;

        // Row-major, always ready: 3 lines of 5, done 1 cycle after last.
        rdy_fix = 1'b1;
        issue(4'b0001, 32'h0000_1000, 32'h40, 8'd3, 8'd5, 2'd0, 4'h3);
        chk("row_busy", busy_o, 1);
        wait_done("row", 4);

        // Col-major with ready toggling every cycle.
        tog = 1'b1;
        issue(4'b0010, 32'h0000_3000, 32'h100, 8'd4, 8'd2, 2'd1, 4'h5);
        wait_done("col", 0);
        tog = 1'b0;
        chk("col_saw_stalls", (stall_cnt > 0), 1);
`ifdef MCTRL_PERF_CNT_EN
        chk("col_perf_stall", perf_stall_o, stall_cnt);
`endif

        // Reshape: T=35, eew=2 -> lens 16,16,3 at +0, +64, +128; stride ignored.
        issue(4'b1000, 32'h0000_2000, 32'h0000_DEAD, 8'd5, 8'd7, 2'd2, 4'h7);
        wait_done("rsh", 4);

        // Transpose flag on both requests.
        issue(4'b0100, 32'h0000_4000, 32'h10, 8'd2, 8'd3, 2'd0, 4'h9);
        wait_done("txp", 3);

        // Illegal modes: no requests, err done on the cycle after accept.
        issue(4'b0011, 32'h0000_5000, 32'h10, 8'd2, 8'd2, 2'd0, 4'hA);
        wait_done("ill2", 1);
        issue(4'b0000, 32'h0000_5000, 32'h10, 8'd2, 8'd2, 2'd0, 4'hB);
        wait_done("ill0", 1);

        // Zero column count: clean done, no requests.
        issue(4'b0001, 32'h0000_6000, 32'h10, 8'd3, 8'd0, 2'd0, 4'hC);
        wait_done("zero", 1);

        // Address wrap: second line at 0x10.
        issue(4'b0001, 32'hFFFF_FFF0, 32'h20, 8'd2, 8'd1, 2'd0, 4'hD);
        wait_done("wrap", 3);

        // Reset while request 1 of 3 is on the port.
        issue(4'b0001, 32'h0000_7000, 32'h8, 8'd3, 8'd2, 2'd0, 4'hE);
        @(posedge clk_i);
        #1;
        rst_i   = 1'b1;
        rdy_fix = 1'b0;
        @(negedge clk_i);
        chk("abort_at_idx1", req_idx_o, 1);
        @(negedge clk_i);
        chk("abort_req_valid", req_valid_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_instr_ready", instr_ready_o, 1);
        chk("abort_busy", busy_o, 0);
`ifdef MCTRL_PERF_CNT_EN
        chk("abort_perf_cleared", perf_stall_o, 0);
`endif
        exp_q.delete();
        stall_cnt = 0;
        rst_i     = 1'b0;
        rdy_fix   = 1'b1;
        issue(4'b0001, 32'h0000_8000, 32'h20, 8'd2, 8'd4, 2'd0, 4'hF);
        chk("post_abort_idx0", req_idx_o, 0);
        wait_done("post_abort", 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
